// File: rtl/led_status_pkg.sv
// led_status_pkg: shared mode encoding, channel phase enum and width helper for the LED engine.
package led_status_pkg;
   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_CODE  = 2'd3;
   typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH, GAP} phase_e;
   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/led_status_ctrl_if.sv
// led_status_ctrl_if: configuration write port of the LED engine.
interface led_status_ctrl_if #(
   parameter int CH_W  = 2,
   parameter int ARG_W = 8
);
   logic             cfg_wr;
   logic [CH_W-1:0]  cfg_ch;
   logic [1:0]       cfg_mode;
   logic [ARG_W-1:0] cfg_arg;
   modport master (output cfg_wr, cfg_ch, cfg_mode, cfg_arg);
   modport slave  (input cfg_wr, cfg_ch, cfg_mode, cfg_arg);
endinterface

// File: rtl/led_status_chan.sv
// led_status_chan: one LED channel; phase FSM, tick timer and CODE pulse counter.
// led is the active-high next-state drive so the top register adds only one cycle of latency.
module led_status_chan
   import led_status_pkg::*;
#(
   parameter int ARG_W      = 8,
   parameter int CODE_ON_T  = 200,
   parameter int CODE_OFF_T = 200,
   parameter int CODE_GAP_T = 1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             wr,
   input  logic [1:0]       mode,
   input  logic [ARG_W-1:0] arg,
   output logic             led
);
   localparam int TW = $clog2(max2(max2(2 ** ARG_W, CODE_ON_T), max2(CODE_OFF_T, CODE_GAP_T)) + 1);

   logic [1:0]       mode_q, mode_d;
   logic [ARG_W-1:0] arg_q, arg_d, pcnt_q, pcnt_d;
   logic [TW-1:0]    tmr_q, tmr_d, tmr_inc, len;
   phase_e           ph_q, ph_d;

   always_comb begin
      mode_d  = mode_q;
      arg_d   = arg_q;
      pcnt_d  = pcnt_q;
      tmr_d   = tmr_q;
      ph_d    = ph_q;
      tmr_inc = tmr_q + TW'(1);
      len     = (mode_q == MODE_BLINK) ? TW'(arg_q) + TW'(1) :
                (ph_q == ON_PH)        ? TW'(CODE_ON_T) :
                (ph_q == OFF_PH)       ? TW'(CODE_OFF_T) : TW'(CODE_GAP_T);
      // a write takes priority over a coincident tick, which is then not counted
      if (wr) begin
         mode_d = mode;
         arg_d  = arg;
         tmr_d  = '0;
         pcnt_d = ARG_W'(1);
         ph_d   = (mode == MODE_BLINK || (mode == MODE_CODE && arg != '0)) ? ON_PH : IDLE;
      end else if (tick && ph_q != IDLE) begin
         tmr_d = tmr_inc;
         if (tmr_inc == len) begin
            tmr_d = '0;
            if (mode_q == MODE_BLINK)
               ph_d = (ph_q == ON_PH) ? OFF_PH : ON_PH;
            else if (ph_q == ON_PH) begin
               ph_d   = (pcnt_q == arg_q) ? GAP : OFF_PH;
               pcnt_d = (pcnt_q == arg_q) ? ARG_W'(1) : pcnt_q + ARG_W'(1);
            end else
               ph_d = ON_PH;
         end
      end
      led = (ph_d == ON_PH) || (mode_d == MODE_ON);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q <= MODE_OFF;
         arg_q  <= '0;
         pcnt_q <= '0;
         tmr_q  <= '0;
         ph_q   <= IDLE;
      end else begin
         mode_q <= mode_d;
         arg_q  <= arg_d;
         pcnt_q <= pcnt_d;
         tmr_q  <= tmr_d;
         ph_q   <= ph_d;
      end
   end
endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel LED indicator engine with shared tick prescaler.
module led_status_ctrl
   import led_status_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CLK_HZ     = 100000000,
   parameter int TICK_HZ    = 1000,
   parameter int ARG_W      = 8,
   parameter int CODE_ON_T  = 200,
   parameter int CODE_OFF_T = 200,
   parameter int CODE_GAP_T = 1000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   led_status_ctrl_if.slave  cfg,
   output logic [NUM_CH-1:0] led_out,
   output logic              tick_out
);
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int CH_W     = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int PW       = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

   if (TICK_DIV < 2) begin : g_bad_div
      $error("led_status_ctrl: CLK_HZ/TICK_HZ must be at least 2");
   end

   logic [PW-1:0]     cnt_q, cnt_d;
   logic              tick_q, tick_d, wr_ok;
   logic [NUM_CH-1:0] led_act, led_q, led_d;

   always_comb begin
      cnt_d  = (cnt_q == PW'(TICK_DIV - 1)) ? '0 : cnt_q + PW'(1);
      tick_d = cnt_q == PW'(TICK_DIV - 1);
      wr_ok  = cfg.cfg_wr && int'(cfg.cfg_ch) < NUM_CH;
      led_d  = led_act ^ {NUM_CH{ACTIVE_LOW}};
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      led_status_chan #(
         .ARG_W(ARG_W), .CODE_ON_T(CODE_ON_T), .CODE_OFF_T(CODE_OFF_T), .CODE_GAP_T(CODE_GAP_T)
      ) u_chan (
         .clk(clk), .reset_n(reset_n), .tick(tick_q),
         .wr(wr_ok && cfg.cfg_ch == CH_W'(i)),
         .mode(cfg.cfg_mode), .arg(cfg.cfg_arg), .led(led_act[i])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         led_q  <= {NUM_CH{ACTIVE_LOW}};
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         led_q  <= led_d;
      end
   end

   assign led_out  = led_q;
   assign tick_out = tick_q;
endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: three builds (4ch active-high, 4ch active-low, 3ch) on one config port,
// checked against a tick-count model of the blink and code patterns.
module tb_led_status_ctrl;
   localparam int ON_T = 2, OFF_T = 2, GAP_T = 5;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] led_a, led_b;
   logic [2:0] led_c;
   logic       tick_a, tick_b, tick_c;
   int         checks = 0, errors = 0;

   led_status_ctrl_if #(.CH_W(2), .ARG_W(8)) cfg ();

   led_status_ctrl #(.NUM_CH(4), .CLK_HZ(1000), .TICK_HZ(100), .ARG_W(8), .CODE_ON_T(ON_T),
      .CODE_OFF_T(OFF_T), .CODE_GAP_T(GAP_T), .ACTIVE_LOW(1'b0)) u_a (
      .clk(clk), .reset_n(reset_n), .cfg(cfg), .led_out(led_a), .tick_out(tick_a));
   led_status_ctrl #(.NUM_CH(4), .CLK_HZ(1000), .TICK_HZ(100), .ARG_W(8), .CODE_ON_T(ON_T),
      .CODE_OFF_T(OFF_T), .CODE_GAP_T(GAP_T), .ACTIVE_LOW(1'b1)) u_b (
      .clk(clk), .reset_n(reset_n), .cfg(cfg), .led_out(led_b), .tick_out(tick_b));
   led_status_ctrl #(.NUM_CH(3), .CLK_HZ(1000), .TICK_HZ(100), .ARG_W(8), .CODE_ON_T(ON_T),
      .CODE_OFF_T(OFF_T), .CODE_GAP_T(GAP_T), .ACTIVE_LOW(1'b0)) u_c (
      .clk(clk), .reset_n(reset_n), .cfg(cfg), .led_out(led_c), .tick_out(tick_c));

   always #5 clk = ~clk;

   // model: each channel counts ticks since its last write; pattern is a function of that count
   int         e = 0, k[4] = '{0, 0, 0, 0}, mm[4] = '{0, 0, 0, 0}, ma[4] = '{0, 0, 0, 0};
   logic       m_tick = 1'b0;
   logic [3:0] exp_led = 4'b0000;

   function automatic logic pattern(input int md, input int a, input int kk);
      int s, p;
      s = ON_T + OFF_T;
      if (md == 1) return 1'b1;
      if (md == 2) return ((kk / (a + 1)) % 2) == 0;
      if (md == 3 && a != 0) begin
         p = kk % (a * ON_T + (a - 1) * OFF_T + GAP_T);
         return (p / s < a) && (p % s < ON_T);
      end
      return 1'b0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e = 0;
         m_tick = 1'b0;
         for (int i = 0; i < 4; i++) begin
            k[i] = 0; mm[i] = 0; ma[i] = 0;
         end
      end else begin
         for (int i = 0; i < 4; i++)
            if (cfg.cfg_wr && cfg.cfg_ch == i) begin
               mm[i] = int'(cfg.cfg_mode); ma[i] = int'(cfg.cfg_arg); k[i] = 0;
            end else if (m_tick) k[i]++;
         e++;
         m_tick = (e % 10) == 0;
      end
      for (int i = 0; i < 4; i++) exp_led[i] = pattern(mm[i], ma[i], k[i]);
   end

   task automatic wr(input int ch, input int md, input int a);
      cfg.cfg_wr = 1'b1; cfg.cfg_ch = ch[1:0]; cfg.cfg_mode = md[1:0]; cfg.cfg_arg = a[7:0];
      @(negedge clk);
      cfg.cfg_wr = 1'b0;
   endtask

   task automatic test_reset();
      int c;
      repeat (3) @(negedge clk);
      checks++;
      if ({led_a, led_b, led_c, tick_a, tick_b, tick_c} !== {4'h0, 4'hF, 3'h0, 3'b000}) begin
         errors++;
         $display("FAIL reset: led_a=%b led_b=%b led_c=%b ticks=%b%b%b want 0000 1111 000 000",
                  led_a, led_b, led_c, tick_a, tick_b, tick_c);
      end
      reset_n = 1'b1;
      c = 0;
      do begin
         @(negedge clk); c++;
      end while (!tick_a && c < 30);
      checks++;
      if (c !== 10) begin errors++; $display("FAIL first_tick: at cycle %0d want 10", c); end
      repeat (35) begin
         @(negedge clk);
         checks++;
         if ({led_a, led_b, led_c, tick_a, tick_b, tick_c} !== {exp_led, ~exp_led, exp_led[2:0], {3{m_tick}}}) begin
            errors++;
            $display("FAIL tick_train: led=%b/%b/%b tick=%b%b%b want led=%b tick=%b",
                     led_a, led_b, led_c, tick_a, tick_b, tick_c, exp_led, m_tick);
         end
      end
   endtask

   task automatic test_on_off();
      wr(1, 1, 0);
      checks++;
      if (led_a !== 4'b0010 || led_b !== 4'b1101) begin
         errors++; $display("FAIL on_write: led_a=%b led_b=%b want 0010 1101", led_a, led_b);
      end
      repeat (4) @(negedge clk);
      wr(1, 0, 0);
      checks++;
      if (led_a !== 4'b0000 || led_b !== 4'b1111) begin
         errors++; $display("FAIL off_write: led_a=%b led_b=%b want 0000 1111", led_a, led_b);
      end
   endtask

   task automatic test_patterns();
      wr(0, 2, 2);
      checks++;
      if (led_a[0] !== 1'b1) begin errors++; $display("FAIL blink_start: led0=%b want 1", led_a[0]); end
      repeat (150) begin
         @(negedge clk);
         checks++;
         if ({led_a, led_b, led_c, tick_a} !== {exp_led, ~exp_led, exp_led[2:0], m_tick}) begin
            errors++;
            $display("FAIL blink: led=%b/%b/%b tick=%b want led=%b tick=%b",
                     led_a, led_b, led_c, tick_a, exp_led, m_tick);
         end
      end
      wr(2, 3, 3);
      repeat (330) begin
         @(negedge clk);
         checks++;
         if ({led_a, led_b, led_c, tick_a} !== {exp_led, ~exp_led, exp_led[2:0], m_tick}) begin
            errors++;
            $display("FAIL code: led=%b/%b/%b tick=%b want led=%b tick=%b",
                     led_a, led_b, led_c, tick_a, exp_led, m_tick);
         end
      end
      wr(2, 3, 0);
      repeat (40) begin
         @(negedge clk);
         checks++;
         if (led_a[2] !== 1'b0 || led_c[2] !== 1'b0) begin
            errors++; $display("FAIL code_zero: led_a2=%b led_c2=%b want 0", led_a[2], led_c[2]);
         end
      end
   endtask

   task automatic test_boundaries();
      int c;
      wr(3, 1, 0);
      checks++;
      if (led_a[3] !== 1'b1 || led_c !== exp_led[2:0]) begin
         errors++; $display("FAIL ch_out_of_range: led_a3=%b led_c=%b want 1 %b", led_a[3], led_c, exp_led[2:0]);
      end
      wr(3, 0, 0);
      c = 0;
      while (!tick_a && c < 20) begin @(negedge clk); c++; end
      wr(0, 2, 2);
      c = 0;
      while (led_a[0] === 1'b1 && c < 100) begin @(negedge clk); c++; end
      checks++;
      if (c !== 30) begin errors++; $display("FAIL write_on_tick: high for %0d cycles want 30", c); end
   endtask

   task automatic test_random();
      repeat (400) begin
         @(negedge clk);
         checks++;
         if ({led_a, led_b, led_c, tick_a, tick_b, tick_c} !== {exp_led, ~exp_led, exp_led[2:0], {3{m_tick}}}) begin
            errors++;
            $display("FAIL random: led=%b/%b/%b tick=%b%b%b want led=%b tick=%b",
                     led_a, led_b, led_c, tick_a, tick_b, tick_c, exp_led, m_tick);
         end
         cfg.cfg_wr   = $urandom_range(0, 9) == 0;
         cfg.cfg_ch   = 2'($urandom_range(0, 3));
         cfg.cfg_mode = 2'($urandom_range(0, 3));
         cfg.cfg_arg  = 8'($urandom_range(0, 3));
      end
      cfg.cfg_wr = 1'b0;
   endtask

   task automatic test_async_reset();
      wr(3, 3, 2);
      repeat (5) @(negedge clk);
      checks++;
      if (led_b[3] !== 1'b0) begin errors++; $display("FAIL code_mid_pulse: led_b3=%b want 0", led_b[3]); end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (led_a !== 4'h0 || led_b !== 4'hF || led_c !== 3'h0) begin
         errors++; $display("FAIL async_reset: led=%b/%b/%b want 0000/1111/000", led_a, led_b, led_c);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         checks++;
         if (led_a !== 4'h0 || led_b !== 4'hF || led_c !== 3'h0 || tick_a !== m_tick) begin
            errors++;
            $display("FAIL after_reset: led=%b/%b/%b tick=%b want 0000/1111/000 tick=%b",
                     led_a, led_b, led_c, tick_a, m_tick);
         end
      end
   endtask

   initial begin
      cfg.cfg_wr = 1'b0; cfg.cfg_ch = '0; cfg.cfg_mode = '0; cfg.cfg_arg = '0;
      test_reset();
      test_on_off();
      test_patterns();
      test_boundaries();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
